// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 MDIO management master; one register command per handshake, frame on MDC/MDIO.
// Optional build macro MDIO_C45_EN enables Clause-45 frames (ST=00, four ops); default is Clause-22 only.
module mdio_master #(
    parameter int CLK_DIV_HALF = 25,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_c45,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        o_mdc,
    output logic        o_mdo,
    output logic        o_mdo_oe,
    input  logic        i_mdi,
    output logic [2:0]  state_dbg
);

    // Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready; cmd_ready is high only
    // in IDLE. Each accepted command yields exactly one rsp_valid pulse (unless reset intervenes).

    localparam int DIV_W = $clog2(CLK_DIV_HALF);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV_HALF - 1);
    localparam logic [5:0] PRE_LAST = 6'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_TA   = 3'd3,
        ST_DATA = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]       bit_q, bit_d;
    logic             mdc_q, mdc_d;
    logic             mdo_q, mdo_d;
    logic             oe_q, oe_d;
    logic [31:0]      tx_q, tx_d;
    logic [15:0]      rx_q, rx_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             rd_q, rd_d;
    logic             ta_err_q, ta_err_d;
    logic             err_q, err_d;

    logic             st_c45;
    logic             op_legal;
    logic             op_read;
    logic [31:0]      frame;
    logic             half_end;
    logic             mdc_rise;
    logic             bit_end;

`ifdef MDIO_C45_EN
    assign st_c45 = cmd_c45;

    always_comb begin
        if (cmd_c45) begin
            op_legal = 1'b1;
            op_read  = cmd_op[1];
        end else begin
            op_legal = (cmd_op == 2'b01) || (cmd_op == 2'b10);
            op_read  = (cmd_op == 2'b10);
        end
    end
`else
    logic c45_unused;
    assign c45_unused = cmd_c45;
    assign st_c45     = 1'b0;
    assign op_legal   = (cmd_op == 2'b01) || (cmd_op == 2'b10);
    assign op_read    = (cmd_op == 2'b10);
`endif

    // Everything after the preamble, MSB first; TA bits are only put on the wire for writes.
    assign frame = {1'b0, ~st_c45, cmd_op, cmd_phy_addr, cmd_reg_addr, 2'b10, cmd_wdata};

    assign half_end = (div_q == DIV_MAX);
    assign mdc_rise = half_end & ~mdc_q;
    assign bit_end  = half_end & mdc_q;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        mdc_d    = mdc_q;
        mdo_d    = mdo_q;
        oe_d     = oe_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        rd_d     = rd_q;
        ta_err_d = ta_err_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                bit_d = '0;
                mdc_d = 1'b0;
                mdo_d = 1'b1;
                oe_d  = 1'b0;
                if (cmd_valid) begin
                    rd_d     = op_read;
                    ta_err_d = 1'b0;
                    tx_d     = frame;
                    if (!op_legal) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else if (PREAMBLE_LEN == 0) begin
                        state_d = ST_HDR;
                        oe_d    = 1'b1;
                        mdo_d   = frame[31];
                        tx_d    = {frame[30:0], 1'b0};
                    end else begin
                        state_d = ST_PRE;
                        oe_d    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                // Bit clock: low half then high half; data moves on the falling edge, sampled on the rising.
                div_d = half_end ? '0 : div_q + DIV_W'(1);
                if (half_end) begin
                    mdc_d = ~mdc_q;
                end
                if (mdc_rise) begin
                    if (state_q == ST_TA && bit_q == 6'd1) begin
                        ta_err_d = i_mdi;
                    end
                    if (state_q == ST_DATA) begin
                        rx_d = {rx_q[14:0], i_mdi};
                    end
                end
                if (bit_end) begin
                    bit_d = bit_q + 6'd1;
                    mdo_d = tx_q[31];
                    tx_d  = {tx_q[30:0], 1'b0};
                    case (state_q)
                        ST_PRE: begin
                            if (bit_q == PRE_LAST) begin
                                state_d = ST_HDR;
                                bit_d   = '0;
                            end else begin
                                mdo_d = 1'b1;
                                tx_d  = tx_q;
                            end
                        end
                        ST_HDR: begin
                            if (bit_q == 6'd13) begin
                                state_d = ST_TA;
                                bit_d   = '0;
                                oe_d    = ~rd_q;
                            end
                        end
                        ST_TA: begin
                            if (bit_q == 6'd1) begin
                                state_d = ST_DATA;
                                bit_d   = '0;
                            end
                        end
                        ST_DATA: begin
                            if (bit_q == 6'd15) begin
                                state_d = ST_DONE;
                                bit_d   = '0;
                                oe_d    = 1'b0;
                                mdo_d   = 1'b1;
                                err_d   = rd_q & ta_err_q;
                                if (rd_q) begin
                                    rdata_d = rx_q;
                                end
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            mdc_q    <= 1'b0;
            mdo_q    <= 1'b1;
            oe_q     <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            rdata_q  <= '0;
            rd_q     <= 1'b0;
            ta_err_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            mdc_q    <= mdc_d;
            mdo_q    <= mdo_d;
            oe_q     <= oe_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            rd_q     <= rd_d;
            ta_err_q <= ta_err_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign o_mdc     = mdc_q;
    assign o_mdo     = mdo_q;
    assign o_mdo_oe  = oe_q;
    assign state_dbg = state_q;

endmodule
